bit_map_alloc_ctrl: RTL and testbench
=====================================

# bit_map_alloc_ctrl

Allocation/free controller in front of the memory-manager free-block bitmap. Arbitrates PORTS allocation requesters round-robin onto bitmap write port 1 (set bit, val=1) at the bitmap's advertised free address. Arbitrates PORTS free requesters round-robin onto bitmap write port 2 (clear bit, val=0). Sits between the per-port cache write logic and the bitmap instance.

## Interface
- PORTS, 4, number of requesters (alloc and free sides each)
- WIDTH, 8, bitmap row width (matches bitmap)
- DEPTH, 8, bitmap row count (matches bitmap)
- ADDR_W, $clog2(WIDTH)+$clog2(DEPTH), block address width
- GAP, 1, idle cycles enforced after each alloc grant so the bitmap's free address settles (0..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 resets at the edge)
- alloc_req  in  PORTS  level request; held until granted
- alloc_gnt  out  PORTS  one-hot, one-cycle grant pulse
- alloc_addr  out  ADDR_W  allocated block address, valid while alloc_gnt!=0
- free_valid  in  PORTS  free request valid
- free_addr  in  PORTS*ADDR_W  port i address at [i*ADDR_W +: ADDR_W]
- free_ready  out  PORTS  one-hot combinational accept
- bm_wr_en_1 / bm_wr_addr_1 / bm_wr_val_1  out  1/ADDR_W/1  bitmap set port
- bm_wr_en_2 / bm_wr_addr_2 / bm_wr_val_2  out  1/ADDR_W/1  bitmap clear port
- bm_emp_ready_addr  in  ADDR_W  bitmap's next free address
- bm_full  in  1  bitmap has no free block
- bm_almost_full  in  1  bitmap nearly full
- alloc_stall  out  1  registered; any unmasked alloc_req pending while bm_full

## Operation
- Alloc FSM states: S_IDLE, S_GNT, S_GAP.
- S_IDLE: if bm_full==0 and masked alloc_req!=0 -> S_GNT; register one-hot winner into alloc_gnt, bm_emp_ready_addr into alloc_addr and bm_wr_addr_1, bm_wr_en_1=1, bm_wr_val_1=1.
- S_GNT lasts exactly one cycle; then S_GAP with counter loaded GAP-1 if GAP>0, else re-evaluate as S_IDLE in the same edge.
- S_GAP: counter decrements; at 0 -> S_IDLE.
- Round-robin pointer advances to the port after the winner. The port granted in the previous cycle is masked at the next arbitration edge (its req may still be high).
- bm_full==1 blocks grants; alloc_stall set; the pending request stays queued, no data lost.
- Free path is independent of the FSM: free_ready is the round-robin one-hot among free_valid; accepted on the edge where free_valid&free_ready. Next cycle: bm_wr_en_2=1, bm_wr_addr_2=address, bm_wr_val_2=0. One free per cycle; own round-robin pointer.
- Alloc and free in the same cycle are both issued (separate bitmap ports).
- Freeing an already-free address is a protocol error and is not detected.

## Timing
- Reset: alloc_gnt=0, alloc_addr=0, free_ready=0 (combinational, gated by reset), all bm_* outputs 0, alloc_stall=0, state S_IDLE, both pointers at port 0, GAP counter 0.
- Alloc latency: req high before edge k -> alloc_gnt/bm_wr_en_1 high in cycle k..k+1.
- Alloc throughput: one grant per GAP+1 cycles.
- Free latency: accept at edge k -> bm_wr_en_2 high in cycle k..k+1; throughput 1/cycle.
- Reset asserted mid-grant or mid-gap aborts at that edge; the bitmap is reset by the same reset.

## Configuration
- BIT_MAP_ALLOC_RESERVE_EN defined: while bm_almost_full==1, only port 0 may be granted. Other ports wait and alloc_stall is set for them. The free path is unaffected.
- BIT_MAP_ALLOC_RESERVE_EN undefined: bm_almost_full is ignored; only bm_full blocks grants.

## Structure
- Shared package mem_mgr_pkg: ADDR_W helper function, alloc FSM state enum, default PORTS/WIDTH/DEPTH constants.
- Sub-module rr_arbiter (parameter N): req, mask, advance enable -> one-hot gnt and internal pointer. Instantiated twice: alloc side (registered use) and free side (combinational use).

## Test plan
- Reset, then port 2 alloc_req with bm_emp_ready_addr=5 -> one-cycle alloc_gnt=4'b0100, alloc_addr=5, bm_wr_en_1=1, bm_wr_addr_1=5, bm_wr_val_1=1.
- All four ports requesting, GAP=1 -> grants in order 0,1,2,3 at cycles 1,3,5,7 after reset release; each port granted once.
- bm_full=1 with port 1 requesting -> no grant, alloc_stall=1; bm_full falls -> grant on the next edge.
- free_valid=4'b1010 with addresses 55 (port 1) and 40 (port 3) -> accepted in consecutive cycles; bm_wr_en_2 pulses with addresses 55 then 40, bm_wr_val_2=0.
- Simultaneous alloc (addr 6) and free (addr 22) in one cycle -> bm_wr_en_1 and bm_wr_en_2 both high in the same cycle.
- With BIT_MAP_ALLOC_RESERVE_EN and bm_almost_full=1: ports 0 and 2 requesting -> only port 0 granted; port 2 stalls until bm_almost_full=0.

Source files
------------

// File: rtl/mem_mgr_pkg.sv
// Shared memory-manager definitions: default sizes, block-address width
// helper and the allocation FSM state encoding.
package mem_mgr_pkg;

    localparam int DEF_PORTS = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT  = 2'd1,
        S_GAP  = 2'd2
    } alloc_state_t;

    // Block address = column bits + row bits of the bitmap.
    function automatic int addr_width(input int width, input int depth);
        return $clog2(width) + $clog2(depth);
    endfunction

endpackage

// File: rtl/bit_map_alloc_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after the
// pointer; the pointer moves to the port after the winner when adv is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         adv,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;
    logic             found;
    logic [N-1:0]     eligible;

    // Combinational winner search starting at the pointer.
    always_comb begin
        eligible = req & ~mask;
        gnt      = '0;
        win_idx  = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && eligible[(int'(ptr) + k) % N]) begin
                found                      = 1'b1;
                win_idx                    = PTR_W'((int'(ptr) + k) % N);
                gnt[(int'(ptr) + k) % N]   = 1'b1;
            end
        end
    end

    // Pointer advances past the winner only when the grant is actually used.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (adv && found) begin
            ptr <= (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bit_map_alloc_ctrl.sv
// Allocation/free controller in front of the free-block bitmap.
// Alloc requesters are granted round-robin onto bitmap set port 1 at the
// bitmap's advertised free address, followed by GAP idle cycles so that
// address can settle. Free requesters are accepted round-robin, one per
// cycle, onto bitmap clear port 2.
// Optional macro BIT_MAP_ALLOC_RESERVE_EN: while bm_almost_full is high only
// port 0 may be granted an allocation.
// Handshakes: alloc_req is a level held until its one-cycle alloc_gnt pulse;
// a free transfers on the rising edge where free_valid & free_ready.
module bit_map_alloc_ctrl
    import mem_mgr_pkg::*;
#(
    parameter int PORTS  = DEF_PORTS,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = addr_width(WIDTH, DEPTH),
    parameter int GAP    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PORTS-1:0]        alloc_req,
    output logic [PORTS-1:0]        alloc_gnt,
    output logic [ADDR_W-1:0]       alloc_addr,
    input  logic [PORTS-1:0]        free_valid,
    input  logic [PORTS*ADDR_W-1:0] free_addr,
    output logic [PORTS-1:0]        free_ready,
    output logic                    bm_wr_en_1,
    output logic [ADDR_W-1:0]       bm_wr_addr_1,
    output logic                    bm_wr_val_1,
    output logic                    bm_wr_en_2,
    output logic [ADDR_W-1:0]       bm_wr_addr_2,
    output logic                    bm_wr_val_2,
    input  logic [ADDR_W-1:0]       bm_emp_ready_addr,
    input  logic                    bm_full,
    input  logic                    bm_almost_full,
    output logic                    alloc_stall,
    output logic [1:0]              alloc_state
);

    alloc_state_t       state;
    logic [3:0]         gap_cnt;
    logic [PORTS-1:0]   allowed;
    logic [PORTS-1:0]   arb_gnt;
    logic               arb_open;
    logic               take;
    logic               stall_next;
    logic [PORTS-1:0]   free_gnt;
    logic               free_take;
    logic [ADDR_W-1:0]  free_sel;

    assign alloc_state = state;

    // Ports currently allowed to compete for an allocation.
    always_comb begin
        allowed = '1;
`ifdef BIT_MAP_ALLOC_RESERVE_EN
        if (bm_almost_full) allowed = PORTS'(1);
`endif
    end

`ifndef BIT_MAP_ALLOC_RESERVE_EN
    logic almost_full_unused;
    assign almost_full_unused = bm_almost_full;
`endif

    // The port granted last cycle is masked so a lingering req is not regranted.
    rr_arbiter #(.N(PORTS)) u_alloc_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (alloc_req & allowed),
        .mask (alloc_gnt),
        .adv  (take),
        .gnt  (arb_gnt)
    );

    // Arbitration edges: idle, end of gap, or straight after a grant when GAP is 0.
    always_comb begin
        arb_open = (state == S_IDLE) ||
                   (state == S_GAP && gap_cnt == 4'd0) ||
                   (state == S_GNT && GAP == 0);
        take     = arb_open && !bm_full && (|arb_gnt);
    end

    // Stall flags any unmasked request that is being held off by the bitmap state.
    always_comb begin
        stall_next = bm_full && (|(alloc_req & ~alloc_gnt));
`ifdef BIT_MAP_ALLOC_RESERVE_EN
        if (bm_almost_full && (|(alloc_req & ~alloc_gnt & ~PORTS'(1))))
            stall_next = 1'b1;
`endif
    end

    // Alloc FSM with registered grant, address and bitmap set-port outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            gap_cnt      <= 4'd0;
            alloc_gnt    <= '0;
            alloc_addr   <= '0;
            bm_wr_en_1   <= 1'b0;
            bm_wr_addr_1 <= '0;
            bm_wr_val_1  <= 1'b0;
            alloc_stall  <= 1'b0;
        end else begin
            alloc_stall <= stall_next;
            alloc_gnt   <= '0;
            bm_wr_en_1  <= 1'b0;
            bm_wr_val_1 <= 1'b0;
            if (take) begin
                state        <= S_GNT;
                alloc_gnt    <= arb_gnt;
                alloc_addr   <= bm_emp_ready_addr;
                bm_wr_addr_1 <= bm_emp_ready_addr;
                bm_wr_en_1   <= 1'b1;
                bm_wr_val_1  <= 1'b1;
            end else begin
                case (state)
                    S_GNT: begin
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= 4'(GAP - 1);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == 4'd0) state <= S_IDLE;
                        else                 gap_cnt <= gap_cnt - 4'd1;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Free side: combinational accept, no masking, own pointer.
    rr_arbiter #(.N(PORTS)) u_free_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (free_valid),
        .mask ('0),
        .adv  (free_take),
        .gnt  (free_gnt)
    );

    assign free_ready  = rst ? free_gnt : '0;
    assign free_take   = |(free_valid & free_ready);
    assign bm_wr_val_2 = 1'b0;

    // Select the accepted port's address.
    always_comb begin
        free_sel = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (free_gnt[i]) free_sel = free_sel | free_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Issue the accepted free to the bitmap clear port one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bm_wr_en_2   <= 1'b0;
            bm_wr_addr_2 <= '0;
        end else begin
            bm_wr_en_2 <= free_take;
            if (free_take) bm_wr_addr_2 <= free_sel;
        end
    end

endmodule

// File: tb/tb_bit_map_alloc_ctrl.sv
// Directed scoreboard bench for bit_map_alloc_ctrl (PORTS=4, ADDR_W=6, GAP=1).
module tb_bit_map_alloc_ctrl;

  localparam int PORTS  = 4;
  localparam int ADDR_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [PORTS-1:0]        alloc_req;
  logic [PORTS-1:0]        alloc_gnt;
  logic [ADDR_W-1:0]       alloc_addr;
  logic [PORTS-1:0]        free_valid;
  logic [PORTS*ADDR_W-1:0] free_addr;
  logic [PORTS-1:0]        free_ready;
  logic                    bm_wr_en_1;
  logic [ADDR_W-1:0]       bm_wr_addr_1;
  logic                    bm_wr_val_1;
  logic                    bm_wr_en_2;
  logic [ADDR_W-1:0]       bm_wr_addr_2;
  logic                    bm_wr_val_2;
  logic [ADDR_W-1:0]       bm_emp_ready_addr;
  logic                    bm_full;
  logic                    bm_almost_full;
  logic                    alloc_stall;
  logic [1:0]              alloc_state;

  logic [PORTS+ADDR_W-1:0] alloc_exp_q[$];
  logic [ADDR_W-1:0]       free_exp_q[$];
  int                      alloc_cyc_q[$];
  int                      free_cyc_q[$];
  logic [PORTS+ADDR_W-1:0] a_exp;
  logic [ADDR_W-1:0]       f_exp;
  logic [PORTS-1:0]        free_acc;
  logic                    addr_inc;
  int                      n_checks = 0;
  int                      n_fail = 0;
  int                      cyc = 0;
  int                      rel_cyc = 0;

  bit_map_alloc_ctrl #(.PORTS(PORTS), .WIDTH(8), .DEPTH(8), .ADDR_W(ADDR_W), .GAP(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_req        (alloc_req),
    .alloc_gnt        (alloc_gnt),
    .alloc_addr       (alloc_addr),
    .free_valid       (free_valid),
    .free_addr        (free_addr),
    .free_ready       (free_ready),
    .bm_wr_en_1       (bm_wr_en_1),
    .bm_wr_addr_1     (bm_wr_addr_1),
    .bm_wr_val_1      (bm_wr_val_1),
    .bm_wr_en_2       (bm_wr_en_2),
    .bm_wr_addr_2     (bm_wr_addr_2),
    .bm_wr_val_2      (bm_wr_val_2),
    .bm_emp_ready_addr(bm_emp_ready_addr),
    .bm_full          (bm_full),
    .bm_almost_full   (bm_almost_full),
    .alloc_stall      (alloc_stall),
    .alloc_state      (alloc_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    #1;
    free_acc = free_valid & free_ready;
    @(posedge clk);
    #1;
    free_valid = free_valid & ~free_acc;
    @(negedge clk);
    if (alloc_gnt != '0) begin
      alloc_req = alloc_req & ~alloc_gnt;
      if (addr_inc) bm_emp_ready_addr = bm_emp_ready_addr + 1'b1;
    end
  endtask

  task automatic wait_alloc(input int budget);
    int n = 0;
    while (alloc_req != '0 && n < budget) begin
      step();
      n++;
    end
    check("alloc_done_in_time", 32'(alloc_req), 0);
  endtask

  task automatic wait_free(input int budget);
    int n = 0;
    while (free_valid != '0 && n < budget) begin
      step();
      n++;
    end
    check("free_done_in_time", 32'(free_valid), 0);
  endtask

  task automatic do_reset(input logic [PORTS-1:0] req_in_reset);
    @(negedge clk);
    rst            = 1'b0;
    alloc_req      = req_in_reset;
    free_valid     = 4'hf;
    free_acc       = '0;
    bm_full        = 1'b0;
    bm_almost_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_alloc_gnt",   32'(alloc_gnt), 0);
    check("rst_alloc_addr",  32'(alloc_addr), 0);
    check("rst_free_ready",  32'(free_ready), 0);
    check("rst_bm_wr_en_1",  32'(bm_wr_en_1), 0);
    check("rst_bm_wr_addr_1", 32'(bm_wr_addr_1), 0);
    check("rst_bm_wr_en_2",  32'(bm_wr_en_2), 0);
    check("rst_bm_wr_addr_2", 32'(bm_wr_addr_2), 0);
    check("rst_alloc_stall", 32'(alloc_stall), 0);
    check("rst_state",       32'(alloc_state), 0);
    free_valid = '0;
    rst        = 1'b1;
    rel_cyc    = cyc;
    alloc_cyc_q.delete();
    free_cyc_q.delete();
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst && alloc_gnt != '0) begin
        if (alloc_exp_q.size() == 0) begin
          check("alloc_unexpected", 32'(alloc_gnt), 0);
        end else begin
          a_exp = alloc_exp_q.pop_front();
          check("alloc_gnt",    32'(alloc_gnt),    32'(a_exp[PORTS+ADDR_W-1:ADDR_W]));
          check("alloc_addr",   32'(alloc_addr),   32'(a_exp[ADDR_W-1:0]));
          check("bm_wr_en_1",   32'(bm_wr_en_1),   1);
          check("bm_wr_addr_1", 32'(bm_wr_addr_1), 32'(a_exp[ADDR_W-1:0]));
          check("bm_wr_val_1",  32'(bm_wr_val_1),  1);
          alloc_cyc_q.push_back(cyc - rel_cyc);
        end
      end else if (bm_wr_en_1) begin
        check("bm_wr_en_1_without_gnt", 32'(bm_wr_en_1), 0);
      end
      if (rst && bm_wr_en_2) begin
        if (free_exp_q.size() == 0) begin
          check("free_unexpected", 32'(bm_wr_en_2), 0);
        end else begin
          f_exp = free_exp_q.pop_front();
          check("bm_wr_addr_2", 32'(bm_wr_addr_2), 32'(f_exp));
          check("bm_wr_val_2",  32'(bm_wr_val_2),  0);
          free_cyc_q.push_back(cyc - rel_cyc);
        end
      end
    end
  end

  // stimulus
  initial begin
    rst = 1'b0; alloc_req = '0; free_valid = '0; free_addr = '0;
    bm_emp_ready_addr = '0; bm_full = 1'b0; bm_almost_full = 1'b0;
    addr_inc = 1'b0; free_acc = '0;

    // single alloc from port 2 at address 5
    do_reset(4'b0000);
    bm_emp_ready_addr = 6'd5;
    alloc_req = 4'b0100;
    alloc_exp_q.push_back({4'b0100, 6'd5});
    wait_alloc(10);
    check("single_grant_count", 32'(alloc_cyc_q.size()), 1);
    repeat (3) step();
    check("idle_after_single", 32'(alloc_state), 0);

    // all four ports, GAP=1: order 0..3 at cycles 1,3,5,7
    bm_emp_ready_addr = 6'd10;
    addr_inc = 1'b1;
    do_reset(4'b1111);
    alloc_exp_q.push_back({4'b0001, 6'd10});
    alloc_exp_q.push_back({4'b0010, 6'd11});
    alloc_exp_q.push_back({4'b0100, 6'd12});
    alloc_exp_q.push_back({4'b1000, 6'd13});
    wait_alloc(40);
    check("rr_grant_count", 32'(alloc_cyc_q.size()), 4);
    if (alloc_cyc_q.size() == 4)
      for (int i = 0; i < 4; i++) check("rr_grant_cycle", 32'(alloc_cyc_q[i]), 32'(1 + 2 * i));
    addr_inc = 1'b0;
    repeat (3) step();

    // bm_full blocks and stalls, grant on the edge after it falls
    do_reset(4'b0000);
    bm_full = 1'b1;
    bm_emp_ready_addr = 6'd33;
    alloc_req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_while_full", 32'(alloc_stall), 1);
      check("no_gnt_while_full", 32'(alloc_gnt), 0);
    end
    bm_full = 1'b0;
    alloc_exp_q.push_back({4'b0010, 6'd33});
    wait_alloc(10);
    check("full_release_cycle", 32'(alloc_cyc_q.size() == 1 ? alloc_cyc_q[0] : -1), 4);
    check("stall_cleared", 32'(alloc_stall), 0);
    repeat (3) step();

    // two frees, ports 1 and 3, accepted back to back
    do_reset(4'b0000);
    free_addr = {6'd40, 6'd0, 6'd55, 6'd0};
    free_valid = 4'b1010;
    #1;
    check("free_ready_first", 32'(free_ready), 32'(4'b0010));
    free_exp_q.push_back(6'd55);
    free_exp_q.push_back(6'd40);
    wait_free(10);
    repeat (2) step();
    check("free_count", 32'(free_cyc_q.size()), 2);
    if (free_cyc_q.size() == 2) begin
      check("free_first_cycle", 32'(free_cyc_q[0]), 1);
      check("free_consecutive", 32'(free_cyc_q[1] - free_cyc_q[0]), 1);
    end

    // simultaneous alloc (6) and free (22)
    do_reset(4'b0000);
    bm_emp_ready_addr = 6'd6;
    alloc_req = 4'b0001;
    free_addr = {6'd0, 6'd22, 6'd0, 6'd0};
    free_valid = 4'b0100;
    alloc_exp_q.push_back({4'b0001, 6'd6});
    free_exp_q.push_back(6'd22);
    step();
    check("sim_bm_wr_en_1", 32'(bm_wr_en_1), 1);
    check("sim_bm_wr_en_2", 32'(bm_wr_en_2), 1);
    repeat (4) step();

    // ports 0 and 2 requesting while almost full
    do_reset(4'b0000);
    bm_almost_full = 1'b1;
    bm_emp_ready_addr = 6'd20;
    addr_inc = 1'b1;
    alloc_req = 4'b0101;
    alloc_exp_q.push_back({4'b0001, 6'd20});
`ifdef BIT_MAP_ALLOC_RESERVE_EN
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("reserve_stall", 32'(alloc_stall), 1);
      check("reserve_no_gnt", 32'(alloc_gnt), 0);
    end
    bm_almost_full = 1'b0;
    alloc_exp_q.push_back({4'b0100, 6'd21});
    wait_alloc(10);
    check("reserve_release_cycle", 32'(alloc_cyc_q.size() == 2 ? alloc_cyc_q[1] : -1), 5);
`else
    alloc_exp_q.push_back({4'b0100, 6'd21});
    wait_alloc(20);
    check("almost_full_ignored_cycle", 32'(alloc_cyc_q.size() == 2 ? alloc_cyc_q[1] : -1), 3);
`endif
    check("stall_after_almost_full", 32'(alloc_stall), 0);
    addr_inc = 1'b0;
    repeat (3) step();

    // final report
    check("alloc_queue_drained", 32'(alloc_exp_q.size()), 0);
    check("free_queue_drained", 32'(free_exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
